// File: rtl/rib_timer.sv
// rib_timer: memory-mapped 32-bit timer on the RIB bus.
// Registers: CTRL (0x00), COUNT (0x04), CMP (0x08), STATUS (0x0C).
// The prescaler produces a tick once every PRE+1 enabled cycles. Each tick
// increments COUNT. A compare match sets the PEND flag and, in auto-reload
// mode, returns COUNT to zero.
// Bus handshake: there is no backpressure. A write commits on every rising
// clk edge that sees we=1. Reads are combinational from wraddr and return
// the value the registers held before any write on the same edge.
module rib_timer #(
  parameter int          PRE_W   = 8,
  parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wraddr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        int_sig
);

  localparam logic [5:0]       OFF_CTRL   = 6'h00;
  localparam logic [5:0]       OFF_COUNT  = 6'h01;
  localparam logic [5:0]       OFF_CMP    = 6'h02;
  localparam logic [5:0]       OFF_STATUS = 6'h03;
  localparam logic [PRE_W-1:0] PCNT_ONE   = PRE_W'(1);

  logic             ctrl_en;
  logic             ctrl_ie;
  logic             ctrl_ar;
  logic [PRE_W-1:0] ctrl_pre;
  logic [31:0]      count;
  logic [31:0]      cmp;
  logic             pend;
  logic [PRE_W-1:0] pcnt;

  logic [5:0] off;
  logic       wr_ctrl;
  logic       wr_count;
  logic       wr_cmp;
  logic       wr_status;
  logic       tick;
  logic       match;
  logic       unused_addr_bits;

  // Only word offsets within the low byte are decoded.
  assign off              = wraddr[7:2];
  assign unused_addr_bits = &{1'b0, wraddr[31:8], wraddr[1:0]};

  assign wr_ctrl   = we && (off == OFF_CTRL);
  assign wr_count  = we && (off == OFF_COUNT);
  assign wr_cmp    = we && (off == OFF_CMP);
  assign wr_status = we && (off == OFF_STATUS);

  // A tick uses the currently registered EN/PRE. A CTRL write in the same
  // cycle affects only later ticks.
  assign tick  = ctrl_en && (pcnt == ctrl_pre);
  assign match = tick && (count == cmp);

  // The interrupt is formed from registered state only.
  assign int_sig = pend & ctrl_ie;

  // Control register. A CTRL write also restarts the prescaler phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en  <= 1'b0;
      ctrl_ie  <= 1'b0;
      ctrl_ar  <= 1'b0;
      ctrl_pre <= '0;
    end else if (wr_ctrl) begin
      ctrl_en  <= wdata[0];
      ctrl_ie  <= wdata[1];
      ctrl_ar  <= wdata[2];
      ctrl_pre <= wdata[8 +: PRE_W];
    end
  end

  // Prescaler: counts enabled cycles and wraps after reaching PRE. A CTRL
  // write forces it back to zero so a new divisor starts from a clean phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (wr_ctrl) begin
      pcnt <= '0;
    end else if (ctrl_en) begin
      if (tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PCNT_ONE;
      end
    end
  end

  // Main counter. A bus write overrides the tick's increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (wr_count) begin
      count <= wdata;
    end else if (tick) begin
      if (match && ctrl_ar) begin
        count <= '0;
      end else begin
        count <= count + 32'd1;
      end
    end
  end

  // Compare register. A new value is seen by the match logic from the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp <= CMP_RST;
    end else if (wr_cmp) begin
      cmp <= wdata;
    end
  end

  // Pending flag. Setting on a match takes priority over a W1C clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
    end else if (match) begin
      pend <= 1'b1;
    end else if (wr_status && wdata[0]) begin
      pend <= 1'b0;
    end
  end

  // Combinational read mux. Unmapped offsets and undefined bits read as zero.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: begin
        rdata[0]          = ctrl_en;
        rdata[1]          = ctrl_ie;
        rdata[2]          = ctrl_ar;
        rdata[8 +: PRE_W] = ctrl_pre;
      end
      OFF_COUNT:  rdata = count;
      OFF_CMP:    rdata = cmp;
      OFF_STATUS: rdata[0] = pend;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_rib_timer.sv
// tb_rib_timer: directed testbench for rib_timer.
// Inputs are driven 1ns after a rising edge. Outputs are sampled before the
// next rising edge.
module tb_rib_timer;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_COUNT  = 32'h04;
  localparam logic [31:0] A_CMP    = 32'h08;
  localparam logic [31:0] A_STATUS = 32'h0C;

  logic        clk;
  logic        rst;
  logic [31:0] wraddr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        int_sig;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] rd;

  rib_timer #(.PRE_W(8), .CMP_RST(32'hFFFF_FFFF)) dut (
    .clk     (clk),
    .rst     (rst),
    .wraddr  (wraddr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .int_sig (int_sig)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks. Each task is entered 1ns after a rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wraddr = a;
    wdata  = d;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we     = 1'b0;
    wdata  = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    wraddr = a;
    #1;
    d = rdata;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; we = 1'b0; wraddr = '0; wdata = '0;
    cycles(2);
    rst = 1'b1;
    cycles(1);
    bus_write(A_COUNT, 32'h55);
    bus_write(A_CTRL, 32'h1);
    cycles(3);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h58) begin err_cnt++; $display("FAIL pre_reset_count got=%h exp=%h", rd, 32'h58); end
    rst = 1'b0;
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL reset_count got=%h exp=%h", rd, 32'h0); end
    bus_read(A_CTRL, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL reset_ctrl got=%h exp=%h", rd, 32'h0); end
    bus_read(A_CMP, rd);
    vec_cnt++; if (rd !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL reset_cmp got=%h exp=%h", rd, 32'hFFFF_FFFF); end
    bus_read(A_STATUS, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h0); end
    vec_cnt++; if (int_sig !== 1'b0) begin err_cnt++; $display("FAIL reset_int got=%b exp=0", int_sig); end
    cycles(1);
    rst = 1'b1;
    cycles(3);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL post_reset_count got=%h exp=%h", rd, 32'h0); end
  endtask

  task automatic test_free_run;
    bus_write(A_CMP, 32'hFFFF_FFFF);
    bus_write(A_CTRL, 32'h1);
    cycles(10);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'd10) begin err_cnt++; $display("FAIL free_run_count got=%h exp=%h", rd, 32'd10); end
    bus_write(A_COUNT, 32'hFFFF_FFFE);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL preload_count got=%h exp=%h", rd, 32'hFFFF_FFFE); end
    cycles(1);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL pre_wrap_count got=%h exp=%h", rd, 32'hFFFF_FFFF); end
    bus_read(A_STATUS, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL pre_wrap_pend got=%h exp=%h", rd, 32'h0); end
    cycles(1);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL wrap_count got=%h exp=%h", rd, 32'h0); end
    bus_read(A_STATUS, rd);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL wrap_pend got=%h exp=%h", rd, 32'h1); end
    vec_cnt++; if (int_sig !== 1'b0) begin err_cnt++; $display("FAIL wrap_int_masked got=%b exp=0", int_sig); end
    bus_write(A_CTRL, 32'h0);
    cycles(4);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL disabled_hold got=%h exp=%h", rd, 32'h1); end
    bus_write(A_STATUS, 32'h0);
    bus_read(A_STATUS, rd);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL w0_no_clear got=%h exp=%h", rd, 32'h1); end
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL w1c_clear got=%h exp=%h", rd, 32'h0); end
  endtask

  task automatic test_auto_reload;
    bus_write(A_COUNT, 32'h0);
    bus_write(A_CMP, 32'd4);
    bus_write(A_CTRL, 32'h0000_0307);
    cycles(19);
    vec_cnt++; if (int_sig !== 1'b0) begin err_cnt++; $display("FAIL ar_int_early got=%b exp=0", int_sig); end
    cycles(1);
    vec_cnt++; if (int_sig !== 1'b1) begin err_cnt++; $display("FAIL ar_int_rise got=%b exp=1", int_sig); end
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL ar_reload_count got=%h exp=%h", rd, 32'h0); end
    bus_write(A_STATUS, 32'h1);
    vec_cnt++; if (int_sig !== 1'b0) begin err_cnt++; $display("FAIL ar_int_clear got=%b exp=0", int_sig); end
    cycles(18);
    vec_cnt++; if (int_sig !== 1'b0) begin err_cnt++; $display("FAIL ar_int_early2 got=%b exp=0", int_sig); end
    cycles(1);
    vec_cnt++; if (int_sig !== 1'b1) begin err_cnt++; $display("FAIL ar_int_rise2 got=%b exp=1", int_sig); end
  endtask

  task automatic test_collisions;
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h1);
    bus_write(A_COUNT, 32'h0);
    bus_write(A_CMP, 32'd2);
    bus_write(A_CTRL, 32'h7);
    cycles(2);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'd2) begin err_cnt++; $display("FAIL col_pre_count got=%h exp=%h", rd, 32'd2); end
    bus_write(A_COUNT, 32'd100);
    bus_read(A_STATUS, rd);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL col_count_pend got=%h exp=%h", rd, 32'h1); end
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'd100) begin err_cnt++; $display("FAIL col_count_val got=%h exp=%h", rd, 32'd100); end
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL col_clear got=%h exp=%h", rd, 32'h0); end
    bus_write(A_COUNT, 32'h0);
    cycles(2);
    bus_read(A_STATUS, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL col_pre_w1c got=%h exp=%h", rd, 32'h0); end
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, rd);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL col_set_wins got=%h exp=%h", rd, 32'h1); end
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL col_reload got=%h exp=%h", rd, 32'h0); end
  endtask

  task automatic test_decode;
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h1);
    bus_write(A_COUNT, 32'h1234);
    bus_write(32'h10, 32'hDEAD_BEEF);
    bus_write(32'hF000_0110, 32'hCAFE_F00D);
    bus_read(32'h10, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL dec_rd_10 got=%h exp=%h", rd, 32'h0); end
    bus_read(32'hFC, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL dec_rd_fc got=%h exp=%h", rd, 32'h0); end
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h1234) begin err_cnt++; $display("FAIL dec_count got=%h exp=%h", rd, 32'h1234); end
    bus_read(32'h0B, rd);
    vec_cnt++; if (rd !== 32'd2) begin err_cnt++; $display("FAIL dec_cmp_lowbits got=%h exp=%h", rd, 32'd2); end
    bus_read(A_CTRL, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL dec_ctrl got=%h exp=%h", rd, 32'h0); end
    bus_read(A_STATUS, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL dec_status got=%h exp=%h", rd, 32'h0); end
    bus_write(A_CTRL, 32'hFFFF_FFFF);
    bus_read(A_CTRL, rd);
    vec_cnt++; if (rd !== 32'h0000_FF07) begin err_cnt++; $display("FAIL dec_ctrl_mask got=%h exp=%h", rd, 32'h0000_FF07); end
    bus_write(A_CTRL, 32'h0);
  endtask

  task automatic test_prescaler_restart;
    bus_write(A_CMP, 32'hFFFF_FFFF);
    bus_write(A_COUNT, 32'h0);
    bus_write(A_STATUS, 32'h1);
    bus_write(A_CTRL, 32'h0000_0501);
    cycles(2);
    bus_write(A_CTRL, 32'h0000_0501);
    cycles(5);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL pre_no_tick got=%h exp=%h", rd, 32'h0); end
    cycles(1);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL pre_tick6 got=%h exp=%h", rd, 32'h1); end
    cycles(6);
    bus_read(A_COUNT, rd);
    vec_cnt++; if (rd !== 32'h2) begin err_cnt++; $display("FAIL pre_tick12 got=%h exp=%h", rd, 32'h2); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_free_run();
    test_auto_reload();
    test_collisions();
    test_decode();
    test_prescaler_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
